// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared definitions for the ex_stage_mc execute stage:
//               function codes, FSM state encoding and instruction fields.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

  // Instruction field positions
  localparam int ADDRCAL_BIT = 28;
  localparam int FUNC_MSB    = 27;
  localparam int FUNC_LSB    = 24;

  // Function codes
  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_SUB  = 4'h1;
  localparam logic [3:0] FN_AND  = 4'h2;
  localparam logic [3:0] FN_OR   = 4'h3;
  localparam logic [3:0] FN_XOR  = 4'h4;
  localparam logic [3:0] FN_SLL  = 4'h5;
  localparam logic [3:0] FN_SRL  = 4'h6;
  localparam logic [3:0] FN_SLTU = 4'h7;
  localparam logic [3:0] FN_MUL  = 4'h8;
  localparam logic [3:0] FN_DIVU = 4'h9;
  localparam logic [3:0] FN_REMU = 4'hA;

  // Execute-stage FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ITER   = 2'd1,
    ST_FINISH = 2'd2
  } ex_state_t;

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_iter
// Description : Iterative unsigned multiply / divide / remainder unit.
//               MUL is shift-add, LSB-first on the multiplier.
//               DIVU/REMU are restoring division, MSB-first on the dividend.
//               One step per cycle, WIDTH steps per operation.
// Ports       : clk, rst          - clock, async active-high reset
//               start             - latch operands and begin (func, a, b)
//               done              - high during the final step cycle
//               result            - valid from the edge after done until
//                                   the next start
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_iter
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic             active;
  logic [CW-1:0]    count;
  logic [3:0]       op;
  // acc: product accumulator (MUL) or partial remainder (DIV)
  // opb: multiplicand shifted left (MUL) or divisor (DIV)
  // q  : multiplier shifted right (MUL) or dividend/quotient (DIV)
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // Partial remainder is always below the divisor, so trial < 2*divisor and
  // the top bit of diff is a clean "trial < divisor" indicator.
  assign trial = {acc, q[WIDTH-1]};
  assign diff  = trial - {1'b0, opb};

  assign done   = active && (count == LAST);
  assign result = (op == FN_DIVU) ? q : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      count  <= '0;
      op     <= '0;
      acc    <= '0;
      opb    <= '0;
      q      <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
      op     <= func;
      acc    <= '0;
      opb    <= b;
      q      <= a;
    end else if (active) begin
      count <= count + 1'b1;
      if (count == LAST) begin
        active <= 1'b0;
      end
      if (op == FN_MUL) begin
        if (q[0]) begin
          acc <= acc + opb;
        end
        opb <= opb << 1;
        q   <= q >> 1;
      end else if (!diff[WIDTH]) begin
        acc <= diff[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], 1'b1};
      end else begin
        acc <= trial[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_stage_mc.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_mc
// Description : Execute stage with valid/ready handshakes. Single-cycle ALU
//               ops load the output register on the accept edge; MUL/DIVU/
//               REMU run through ex_muldiv_iter over WIDTH cycles.
// Ports       : ClockInput, ResetInput   - clock, async active-high reset
//               InValid/InReady          - upstream handshake
//               Instruction              - [28] AddrCal, [27:24] Function,
//                                          [OFFSET_WIDTH-1:0] offset
//               PriOperand, SecOperand   - operands A and B
//               OutValid/OutReady        - downstream handshake
//               Result, ZeroFlag, DivZero, IllegalOp - registered outputs
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int OFFSET_WIDTH = 20,
  parameter int MULDIV_EN    = 1
) (
  input  logic             ClockInput,
  input  logic             ResetInput,
  input  logic             InValid,
  output logic             InReady,
  input  logic [31:0]      Instruction,
  input  logic [WIDTH-1:0] PriOperand,
  input  logic [WIDTH-1:0] SecOperand,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             ZeroFlag,
  output logic             DivZero,
  output logic             IllegalOp
);

  localparam int SHW   = $clog2(WIDTH);
  localparam bit MD_ON = (MULDIV_EN != 0);

  ex_state_t        state;
  logic [3:0]       func;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             accept;
  logic             out_free;
  logic             is_md_fn;
  logic             div_zero;
  logic             md_start;
  logic             sc_load;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] sc_result;
  logic             sc_divzero;
  logic             sc_illegal;
  logic             unused_instr;

  // Bits outside the decoded fields are don't-care.
  assign unused_instr = ^Instruction;

  assign func = Instruction[FUNC_MSB:FUNC_LSB];
  assign op_a = PriOperand;
  assign op_b = Instruction[ADDRCAL_BIT]
              ? {{(WIDTH-OFFSET_WIDTH){1'b0}}, Instruction[OFFSET_WIDTH-1:0]}
              : SecOperand;

  assign out_free = !OutValid || OutReady;
  assign InReady  = (state == ST_IDLE) && out_free;
  assign accept   = InValid && InReady;

  assign is_md_fn = (func == FN_MUL) || (func == FN_DIVU) || (func == FN_REMU);
  assign div_zero = ((func == FN_DIVU) || (func == FN_REMU)) && (op_b == '0);
  // Divide-by-zero is resolved on the accept edge and never iterates.
  assign md_start = accept && MD_ON && is_md_fn && !div_zero;
  assign sc_load  = accept && !md_start;

  always_comb begin
    sc_result  = '0;
    sc_divzero = 1'b0;
    sc_illegal = 1'b0;
    case (func)
      FN_ADD:  sc_result = op_a + op_b;
      FN_SUB:  sc_result = op_a - op_b;
      FN_AND:  sc_result = op_a & op_b;
      FN_OR:   sc_result = op_a | op_b;
      FN_XOR:  sc_result = op_a ^ op_b;
      FN_SLL:  sc_result = op_a << op_b[SHW-1:0];
      FN_SRL:  sc_result = op_a >> op_b[SHW-1:0];
      FN_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      // With MD_ON, a MUL never takes the single-cycle path.
      FN_MUL:  sc_illegal = !MD_ON;
      FN_DIVU: begin
        if (MD_ON) begin
          sc_result  = '1;
          sc_divzero = 1'b1;
        end else begin
          sc_illegal = 1'b1;
        end
      end
      FN_REMU: begin
        if (MD_ON) begin
          sc_result  = op_a;
          sc_divzero = 1'b1;
        end else begin
          sc_illegal = 1'b1;
        end
      end
      default: sc_illegal = 1'b1;
    endcase
  end

  ex_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (ClockInput),
    .rst    (ResetInput),
    .start  (md_start),
    .func   (func),
    .a      (op_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge ClockInput or posedge ResetInput) begin
    if (ResetInput) begin
      state     <= ST_IDLE;
      OutValid  <= 1'b0;
      Result    <= '0;
      ZeroFlag  <= 1'b0;
      DivZero   <= 1'b0;
      IllegalOp <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:   if (md_start) state <= ST_ITER;
        ST_ITER:   if (md_done)  state <= ST_FINISH;
        ST_FINISH: if (out_free) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase

      if (sc_load) begin
        OutValid  <= 1'b1;
        Result    <= sc_illegal ? '0 : sc_result;
        ZeroFlag  <= sc_illegal ? 1'b1 : (sc_result == '0);
        DivZero   <= sc_divzero && !sc_illegal;
        IllegalOp <= sc_illegal;
      end else if ((state == ST_FINISH) && out_free) begin
        OutValid  <= 1'b1;
        Result    <= md_result;
        ZeroFlag  <= (md_result == '0);
        DivZero   <= 1'b0;
        IllegalOp <= 1'b0;
      end else if (OutValid && OutReady) begin
        OutValid  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage_mc
// Description : Scoreboard testbench for ex_stage_mc (WIDTH=32). Stimulus
//               pushes hand-computed expectations; a negedge monitor pops
//               and compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage_mc;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pri_op;
  logic [31:0] sec_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero_flag;
  logic        div_zero;
  logic        illegal_op;

  typedef struct packed {
    logic [31:0] res;
    logic        zf;
    logic        dz;
    logic        il;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_stage_mc #(
    .WIDTH        (32),
    .OFFSET_WIDTH (20),
    .MULDIV_EN    (1)
  ) dut (
    .ClockInput  (clk),
    .ResetInput  (rst),
    .InValid     (in_valid),
    .InReady     (in_ready),
    .Instruction (instr),
    .PriOperand  (pri_op),
    .SecOperand  (sec_op),
    .OutValid    (out_valid),
    .OutReady    (out_ready),
    .Result      (result),
    .ZeroFlag    (zero_flag),
    .DivZero     (div_zero),
    .IllegalOp   (illegal_op)
  );

  // Monitor: each negedge with OutValid && OutReady is one transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%h", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({result, zero_flag, div_zero, illegal_op} !== e) begin
          errors++;
          $display("FAIL sb_result got=%h z=%b dz=%b il=%b exp=%h z=%b dz=%b il=%b",
                   result, zero_flag, div_zero, illegal_op, e.res, e.zf, e.dz, e.il);
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [3:0] fn, input logic ac,
                                     input logic [19:0] off);
    return {3'b000, ac, fn, 4'h0, off};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op until accepted; returns 1 time unit after the accept edge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic edz, input logic eil,
                       input bit push);
    bit got;
    got      = 1'b0;
    instr    = ins;
    pri_op   = a;
    sec_op   = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout ins=%h got=no_accept exp=accept", ins);
    end else if (push) begin
      sb.push_back({er, (er == 32'h0), edz, eil});
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (sb.size() == 0 && !out_valid) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    pri_op    = '0;
    sec_op    = '0;
    repeat (3) tick();
    chk("rst_outvalid", {31'b0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {29'b0, zero_flag, div_zero, illegal_op}, 32'h0);
    rst = 1'b0;
    tick();
    chk("rst_inready", {31'b0, in_ready}, 32'h1);

    // ADD wrap to zero, visible one cycle after accept
    issue(mk(FN_ADD, 1'b0, 20'h0), 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("add_wrap_valid", {31'b0, out_valid}, 32'h1);
    chk("add_wrap_zf", {31'b0, zero_flag}, 32'h1);

    // Four back-to-back ADDs: OutValid high on each consecutive cycle
    issue(mk(FN_ADD, 1'b0, 20'h0), 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b1);
    chk("b2b_valid0", {31'b0, out_valid}, 32'h1);
    issue(mk(FN_ADD, 1'b0, 20'h0), 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b1);
    chk("b2b_valid1", {31'b0, out_valid}, 32'h1);
    issue(mk(FN_ADD, 1'b0, 20'h0), 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    chk("b2b_valid2", {31'b0, out_valid}, 32'h1);
    issue(mk(FN_ADD, 1'b0, 20'h0), 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b1);
    chk("b2b_valid3", {31'b0, out_valid}, 32'h1);

    // AddrCal: offset replaces SecOperand
    issue(mk(FN_ADD, 1'b1, 20'h00010), 32'h100, 32'hDEAD_BEEF, 32'h110, 1'b0, 1'b0, 1'b1);

    // Remaining single-cycle ops
    issue(mk(FN_AND, 1'b0, 20'h0), 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1'b1);
    issue(mk(FN_OR, 1'b0, 20'h0), 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1'b0, 1'b1);
    issue(mk(FN_SLL, 1'b0, 20'h0), 32'h1, 32'd36, 32'h10, 1'b0, 1'b0, 1'b1);
    issue(mk(FN_SRL, 1'b0, 20'h0), 32'h8000_0000, 32'd31, 32'h1, 1'b0, 1'b0, 1'b1);
    issue(mk(FN_SLTU, 1'b0, 20'h0), 32'd3, 32'd5, 32'h1, 1'b0, 1'b0, 1'b1);
    issue(mk(FN_SLTU, 1'b0, 20'h0), 32'hFFFF_FFFF, 32'd3, 32'h0, 1'b0, 1'b0, 1'b1);
    drain();

    // MUL latency: OutValid exactly 33 cycles after accept, InReady low meanwhile
    issue(mk(FN_MUL, 1'b0, 20'h0), 32'h0001_0003, 32'h5, 32'h0005_000F, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= 32; k++) begin
      chk($sformatf("mul_wait_%0d", k), {30'b0, out_valid, in_ready}, 32'h0);
      tick();
    end
    chk("mul_valid_at_33", {31'b0, out_valid}, 32'h1);
    drain();

    // Divide / remainder, including divide by zero
    issue(mk(FN_DIVU, 1'b0, 20'h0), 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b1);
    issue(mk(FN_REMU, 1'b0, 20'h0), 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 1'b1);
    drain();
    issue(mk(FN_DIVU, 1'b0, 20'h0), 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    chk("divz_valid", {31'b0, out_valid}, 32'h1);
    chk("divz_result", result, 32'hFFFF_FFFF);
    chk("divz_flag", {31'b0, div_zero}, 32'h1);
    issue(mk(FN_REMU, 1'b0, 20'h0), 32'd5, 32'd0, 32'd5, 1'b1, 1'b0, 1'b1);
    issue(mk(FN_MUL, 1'b0, 20'h0), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
    drain();

    // Backpressure: SUB result held for 10 cycles, next op waits
    out_ready = 1'b0;
    issue(mk(FN_SUB, 1'b0, 20'h0), 32'h10, 32'h20, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1);
    instr    = mk(FN_XOR, 1'b0, 20'h0);
    pri_op   = 32'h0000_F0F0;
    sec_op   = 32'h0000_0FF0;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp_hold_%0d", k), result, 32'hFFFF_FFF0);
      chk($sformatf("bp_ready_%0d", k), {30'b0, out_valid, in_ready}, 32'h2);
      tick();
    end
    sb.push_back({32'h0000_FF00, 1'b0, 1'b0, 1'b0});
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_second_result", result, 32'h0000_FF00);
    chk("bp_second_valid", {31'b0, out_valid}, 32'h1);

    // Illegal function code
    issue(mk(4'hC, 1'b0, 20'h0), 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("illegal_flag", {31'b0, illegal_op}, 32'h1);
    drain();

    // Reset at iteration 5 of a DIVU: nothing may emerge afterwards
    issue(mk(FN_DIVU, 1'b0, 20'h0), 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("midrst_outvalid", {31'b0, out_valid}, 32'h0);
    rst = 1'b0;
    tick();
    chk("midrst_inready", {31'b0, in_ready}, 32'h1);
    for (int k = 0; k < 45; k++) begin
      if (out_valid) begin
        chk("midrst_stale", {31'b0, out_valid}, 32'h0);
        break;
      end
      tick();
    end
    issue(mk(FN_ADD, 1'b0, 20'h0), 32'd40, 32'd2, 32'd42, 1'b0, 1'b0, 1'b1);
    drain();
    chk("sb_empty", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised next-generation execute stage.
- Single-cycle ALU ops complete with a registered 1-cycle latency.
- Iterative multiply/divide/remainder run over WIDTH cycles.
- Sits between the ID pipeline register and the MEM stage; valid/ready handshakes on both sides replace the free-running combinational path.

Parameters:
WIDTH, 32, datapath width of operands and result (>=8).
OFFSET_WIDTH, 20, width of the zero-extended immediate taken from Instruction[OFFSET_WIDTH-1:0] (OFFSET_WIDTH < WIDTH).
MULDIV_EN, 1, 0 = MUL/DIVU/REMU decode as illegal.

Ports:
ClockInput  in  1  clock, rising edge.
ResetInput  in  1  asynchronous, active-high reset.
InValid  in  1  Instruction/operands valid.
InReady  out  1  stage accepts an op this cycle.
Instruction  in  32  [28]=AddrCal (1: second operand is offset), [27:24]=Function, [OFFSET_WIDTH-1:0]=offset.
PriOperand  in  WIDTH  first operand.
SecOperand  in  WIDTH  second operand.
OutValid  out  1  Result valid.
OutReady  in  1  downstream accepts Result.
Result  out  WIDTH  registered result.
ZeroFlag  out  1  Result == 0.
DivZero  out  1  DIVU/REMU with divisor 0.
IllegalOp  out  1  undefined Function code.

Behaviour:
- Reset (async, any state, including mid-iteration):
  - State=IDLE; OutValid, Result, ZeroFlag, DivZero, IllegalOp, iteration counter all 0.
  - InReady=1 once reset deasserts.
  - An in-flight op is discarded.
- Operand B = AddrCal ? zero-extended offset : SecOperand.
- Function codes:
  - 0 ADD, 1 SUB (A-B, modulo 2^WIDTH), 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL: shift amount B[log2(WIDTH)-1:0].
  - 7 SLTU: unsigned, result 1 or 0.
  - 8 MUL (low WIDTH bits), 9 DIVU, A REMU.
  - B-F illegal.
- Handshake:
  - Accept = InValid && InReady.
  - InReady = (state==IDLE) && (!OutValid || OutReady).
  - Output register holds Result/flags stable while OutValid && !OutReady.
  - OutValid drops the cycle after OutValid && OutReady unless a new result loads that same edge.
- Single-cycle ops (0-7) and illegal codes: result loaded on the accept edge, so OutValid rises the next cycle.
  - Back-to-back throughput: 1 op/cycle when OutReady held high.
  - Illegal: Result=0, IllegalOp=1, ZeroFlag=1.
- Multi-cycle ops (8-A), FSM:
  - IDLE: on accept of a MUL/DIV op, latch A and B, Count=0, go to ITER. InReady=0 throughout ITER and FINISH.
  - ITER: one step per cycle, Count increments. When Count==WIDTH-1, go to FINISH.
    - MUL: shift-add, LSB-first on multiplier.
    - DIVU/REMU: restoring, MSB-first.
  - FINISH: wait until !OutValid || OutReady, then load the output register and go to IDLE.
  - Latency accept -> OutValid = WIDTH+1 cycles when the output is free.
- Divide by zero: no iteration; result loaded on the accept edge.
  - DIVU: Result = all ones. REMU: Result = A.
  - DivZero=1.
- Flags are registered with Result; DivZero and IllegalOp are 0 for all other results.
- MULDIV_EN=0: codes 8-A behave as illegal; the FSM never leaves IDLE.
- InValid while InReady=0: ignored. Upstream holds the instruction until accepted.

Decomposition:
- Shared package ex_pkg:
  - Function code constants (FN_ADD..FN_REMU).
  - FSM state encoding (IDLE, ITER, FINISH).
  - Instruction field positions (ADDRCAL_BIT, FUNC_MSB/LSB).
- One sub-module, ex_muldiv_iter:
  - Owns the latched operands, Count and the shift-add/restoring-divide datapath.
  - start/done interface.
  - Top level keeps the handshake, single-cycle ALU and output register.

Test Plan:
- Reset mid-DIVU (assert at iteration 5) -> OutValid=0 next edge, InReady=1 after release, no stale result emerges.
- ADD A=0xFFFFFFFF, B=1, OutReady=1 -> Result=0, ZeroFlag=1 one cycle after accept. Then 4 back-to-back ADDs -> 4 consecutive OutValid cycles.
- AddrCal=1, Function=ADD, Instruction[19:0]=0x00010, PriOperand=0x100 -> Result=0x110, SecOperand ignored.
- MUL 0x0001_0003 x 0x0000_0005 -> Result=0x0005_000F, OutValid exactly 33 cycles after accept, InReady=0 throughout.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF with DivZero=1 one cycle after accept; REMU 5/0 -> 5.
- Backpressure: OutReady=0 for 10 cycles after an SUB result -> Result stable, InReady=0, second op accepted only after the OutReady pulse. Function=0xC -> IllegalOp=1, Result=0.
